pc_gen_bp: RTL and testbench

PC_GEN_BP -- requirements
Module: pc_gen_bp

---
 rtl/pc_gen_bp.sv | 75 +++++++
 tb/tb_pc_gen_bp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_bp.sv
// pc_gen_bp: fetch PC generator with a direct-mapped branch target buffer.
// Define PC_GEN_BP_BHT_EN to add 2-bit direction counters to each BTB entry.
module pc_gen_bp #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [15:0]     mispred_cnt
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IDX - 2;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TW-1:0] tag_q [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_q [BTB_ENTRIES];
  logic [IDX-1:0] ridx, uidx;
  logic hit, uhit, clr_v, unused;
  assign ridx = pc_q[IDX+1:2];
  assign uidx = upd_pc[IDX+1:2];
  assign hit = valid_q[ridx] && tag_q[ridx] == pc_q[XLEN-1:IDX+2];
  assign uhit = valid_q[uidx] && tag_q[uidx] == upd_pc[XLEN-1:IDX+2];
  assign unused = ^upd_pc[1:0];
  assign pc = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign pred_target = pred_taken ? tgt_q[ridx] : '0;
  assign mispred_cnt = cnt_q;
`ifdef PC_GEN_BP_BHT_EN
  logic [1:0] ctr_q [BTB_ENTRIES];
  assign pred_taken = hit && ctr_q[ridx][1];
  assign clr_v = 1'b0;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= 2'd1;
    end else if (upd_valid && upd_taken) begin
      ctr_q[uidx] <= !uhit ? 2'd2 : ctr_q[uidx] == 2'd3 ? 2'd3 : ctr_q[uidx] + 2'd1;
    end else if (upd_valid && uhit && ctr_q[uidx] != 2'd0) begin
      ctr_q[uidx] <= ctr_q[uidx] - 2'd1;
    end
`else
  assign pred_taken = hit;
  assign clr_v = upd_valid && !upd_taken && uhit;
`endif
  always_comb begin
    pc_d = rst ? RESET_VEC : redirect ? redirect_pc : stall ? pc_q : pred_taken ? pred_target : pc_plus4;
    cnt_d = rst ? 16'd0 : (redirect && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    cnt_q <= cnt_d;
  end
  always_ff @(posedge clk)
    if (rst) valid_q <= '0;
    else if (upd_valid && upd_taken) valid_q[uidx] <= 1'b1;
    else if (clr_v) valid_q[uidx] <= 1'b0;
  // Tag and target carry no reset; valid gates their use.
  always_ff @(posedge clk)
    if (!rst && upd_valid && upd_taken) begin
      tag_q[uidx] <= upd_pc[XLEN-1:IDX+2];
      tgt_q[uidx] <= upd_target;
    end
endmodule

// File: tb/tb_pc_gen_bp.sv
// tb_pc_gen_bp: directed scenarios plus random traffic against a behavioural BTB model.
module tb_pc_gen_bp;
  localparam int N = 16;
  localparam logic [31:0] RV = 32'h100;
  logic clk = 1'b0;
  logic rst, stall, redirect, upd_valid, upd_taken, pred_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, pc, pc_plus4, pred_target;
  logic [15:0] mispred_cnt;
  int errors = 0, checks = 0;
  logic [31:0] m_pc = 32'h0;
  bit m_v [N];
  logic [31:0] m_tag [N], m_tgt [N];
  int m_ctr [N];
  int m_cnt = 0;

  always #5 clk = ~clk;

  pc_gen_bp #(.XLEN(32), .BTB_ENTRIES(N), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken), .pred_target(pred_target),
    .mispred_cnt(mispred_cnt)
  );

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int i = idx_of(a);
    return m_v[i] && m_tag[i] == tag_of(a);
  endfunction

  function automatic bit m_pred();
`ifdef PC_GEN_BP_BHT_EN
    return m_hit(m_pc) && m_ctr[idx_of(m_pc)] >= 2;
`else
    return m_hit(m_pc);
`endif
  endfunction

  function automatic logic [31:0] pool();
    return 32'h100 + (32'($urandom_range(31)) << 2) + ($urandom_range(3) == 0 ? 32'h1000 : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input bit chk);
    bit p, h;
    int i;
    logic [31:0] pt;
    p = m_pred();
    pt = p ? m_tgt[idx_of(m_pc)] : 32'h0;
    if (chk) begin
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
      check({tag, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, p});
      check({tag, ".pred_target"}, pred_target, pt);
      check({tag, ".mispred_cnt"}, {16'b0, mispred_cnt}, 32'(m_cnt));
    end
    if (rst) begin
      m_pc = RV;
      m_cnt = 0;
      for (int k = 0; k < N; k++) begin
        m_v[k] = 1'b0;
        m_ctr[k] = 1;
      end
    end else begin
      m_pc = redirect ? redirect_pc : stall ? m_pc : p ? pt : m_pc + 32'd4;
      if (redirect && m_cnt < 65535) m_cnt++;
      if (upd_valid) begin
        i = idx_of(upd_pc);
        h = m_hit(upd_pc);
        if (upd_taken) begin
          if (!h) begin
            m_v[i] = 1'b1;
            m_tag[i] = tag_of(upd_pc);
            m_ctr[i] = 2;
          end else if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = upd_target;
        end else if (h) begin
`ifdef PC_GEN_BP_BHT_EN
          if (m_ctr[i] > 0) m_ctr[i]--;
`else
          m_v[i] = 1'b0;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg);
    upd_valid = 1'b1;
    upd_pc = a;
    upd_taken = t;
    upd_target = tg;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m_v[k] = 1'b0;
      m_ctr[k] = 1;
    end
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_pc = '0; upd_target = '0;
    tick("rst0", 1'b0);
    upd(32'h108, 1'b1, 32'h200);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick("rst1", 1'b1);
    rst = 1'b0; upd_valid = 1'b0; redirect = 1'b0;
    check("reset_pc", pc, 32'h100);
    check("reset_pred", {31'b0, pred_taken}, 32'h0);
    check("reset_cnt", {16'b0, mispred_cnt}, 32'h0);
    tick("run0", 1'b1);
    check("pc_104", pc, 32'h104);
    upd(32'h108, 1'b1, 32'h200);
    tick("alloc", 1'b1);
    upd_valid = 1'b0;
    check("alloc_pred", {31'b0, pred_taken}, 32'h1);
    check("alloc_tgt", pred_target, 32'h200);
    tick("pred", 1'b1);
    check("pred_pc", pc, 32'h200);
    redirect = 1'b1; redirect_pc = 32'h108;
    upd(32'h108, 1'b0, 32'h0);
    tick("nt1", 1'b1);
    redirect = 1'b0; stall = 1'b1;
    tick("nt2", 1'b1);
    upd_valid = 1'b0;
    check("nt_pred", {31'b0, pred_taken}, 32'h0);
    upd(32'h108, 1'b1, 32'h200);
    repeat (3) tick("tk", 1'b1);
    upd_valid = 1'b0;
    check("tk_pred", {31'b0, pred_taken}, 32'h1);
    upd(32'h108, 1'b0, 32'h0);
    tick("sat_dec", 1'b1);
    upd_valid = 1'b0;
`ifdef PC_GEN_BP_BHT_EN
    check("ctr3_pred", {31'b0, pred_taken}, 32'h1);
`else
    check("clr_pred", {31'b0, pred_taken}, 32'h0);
`endif
    redirect = 1'b1; redirect_pc = 32'h40;
    tick("prio", 1'b1);
    redirect = 1'b0;
    check("prio_pc", pc, 32'h40);
    repeat (3) begin
      tick("hold", 1'b1);
      check("hold_pc", pc, 32'h40);
    end
    upd(32'h108, 1'b1, 32'h200);
    tick("al1", 1'b1);
    upd(32'h148, 1'b1, 32'h300);
    tick("al2", 1'b1);
    upd_valid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h108;
    tick("al3", 1'b1);
    redirect = 1'b0;
    check("alias_miss", {31'b0, pred_taken}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h148;
    tick("al4", 1'b1);
    redirect = 1'b0;
    upd(32'h148, 1'b1, 32'h400);
    check("same_cyc_old", pred_target, 32'h300);
    tick("al5", 1'b1);
    upd_valid = 1'b0;
    check("same_cyc_new", pred_target, 32'h400);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick("wr0", 1'b1);
    redirect = 1'b0; stall = 1'b0;
    check("wrap_plus4", pc_plus4, 32'h0);
    tick("wr1", 1'b1);
    check("wrap_pc", pc, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    repeat (65540) tick("sat", 1'b0);
    redirect = 1'b0;
    check("cnt_sat", {16'b0, mispred_cnt}, 32'hFFFF);
    tick("satchk", 1'b1);
    repeat (600) begin
      rst = $urandom_range(99) == 0;
      stall = $urandom_range(4) == 0;
      redirect = $urandom_range(9) == 0;
      redirect_pc = pool();
      upd(pool(), 1'($urandom_range(1)), pool());
      upd_valid = $urandom_range(2) != 0;
      tick("rnd", 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
